// File: rtl/piezo_seq.sv
// Table-driven melody sequencer driving a differential piezo pair: low-battery jingle or victory fanfare.
// Optional PIEZO_VOL_EN adds a 2-bit vol input that scales the tone duty cycle.
module piezo_seq #(
   parameter int FAST_SIM = 1,
   parameter int BEAT_CYC = 8388608,
   parameter int GAP_CYC  = 0,
   parameter int DUR_W    = 24,
   parameter int FREQ_W   = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       batt_low,
   input  logic       fanfare,
`ifdef PIEZO_VOL_EN
   input  logic [1:0] vol,
`endif
   output logic       piezo,
   output logic       piezo_n,
   output logic       busy,
   output logic [2:0] note_idx,
   output logic       done
);

   localparam int STEP = (FAST_SIM != 0) ? 16 : 1;

   localparam logic [FREQ_W:0] STEP_F = (FREQ_W+1)'(STEP);
   localparam logic [DUR_W:0]  STEP_D = (DUR_W+1)'(STEP);
   localparam logic [DUR_W:0]  DUR_1  = (DUR_W+1)'(BEAT_CYC);
   localparam logic [DUR_W:0]  DUR_15 = (DUR_W+1)'(BEAT_CYC + BEAT_CYC / 2);
   localparam logic [DUR_W:0]  GAP_L  = (DUR_W+1)'(GAP_CYC);

   localparam logic MEL_LOW = 1'b0;
   localparam logic MEL_FAN = 1'b1;

   localparam logic [1:0] T_G6 = 2'd0;
   localparam logic [1:0] T_C7 = 2'd1;
   localparam logic [1:0] T_E7 = 2'd2;
   localparam logic [1:0] T_G7 = 2'd3;

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t            state;
   logic              mel;
   logic              fan_pend;
   logic [FREQ_W-1:0] freq_cnt;
   logic [DUR_W-1:0]  dur_cnt;

   function automatic logic [1:0] tone_of(input logic m, input logic [2:0] idx);
      logic [1:0] t;
      t = T_G7;
      if (m == MEL_LOW) begin
         case (idx)
            3'd0:    t = T_G6;
            3'd1:    t = T_C7;
            default: t = T_E7;
         endcase
      end else begin
         case (idx)
            3'd0:    t = T_G6;
            3'd1:    t = T_C7;
            3'd2:    t = T_E7;
            3'd3:    t = T_G7;
            3'd4:    t = T_E7;
            default: t = T_G7;
         endcase
      end
      return t;
   endfunction

   function automatic logic [15:0] period_of(input logic [1:0] t);
      case (t)
         T_G6:    return 16'd31888;
         T_C7:    return 16'd23890;
         T_E7:    return 16'd18960;
         default: return 16'd15943;
      endcase
   endfunction

   function automatic logic [15:0] half_of(input logic [1:0] t);
      case (t)
         T_G6:    return 16'd15944;
         T_C7:    return 16'd11945;
         T_E7:    return 16'd9480;
         default: return 16'd7972;
      endcase
   endfunction

   logic [1:0]      tone;
   logic [FREQ_W:0] period;
   logic [FREQ_W:0] half;
   logic [FREQ_W:0] hi_lim;
   logic [FREQ_W:0] freq_sum;
   logic [DUR_W:0]  dur_sum;
   logic [DUR_W:0]  dur_lim;
   logic            tone_on;
   logic            note_end;
   logic            gap_end;
   logic            freq_wrap;
   logic            last_note;

   always_comb begin
      tone      = tone_of(mel, note_idx);
      period    = (FREQ_W+1)'(period_of(tone));
      half      = (FREQ_W+1)'(half_of(tone));
`ifdef PIEZO_VOL_EN
      hi_lim    = half >> (2'd3 - vol);
      tone_on   = (vol != 2'd0) && ({1'b0, freq_cnt} < hi_lim);
`else
      hi_lim    = half;
      tone_on   = ({1'b0, freq_cnt} < hi_lim);
`endif
      freq_sum  = {1'b0, freq_cnt} + STEP_F;
      freq_wrap = (freq_sum >= period);
      dur_sum   = {1'b0, dur_cnt} + STEP_D;
      // G7 is the only 1.5-beat note, and only in the fanfare
      dur_lim   = (mel == MEL_FAN && tone == T_G7) ? DUR_15 : DUR_1;
      note_end  = (dur_sum >= dur_lim);
      gap_end   = (dur_sum >= GAP_L);
      last_note = (mel == MEL_LOW) ? (note_idx == 3'd2) : (note_idx == 3'd5);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mel      <= MEL_LOW;
         fan_pend <= 1'b0;
         freq_cnt <= '0;
         dur_cnt  <= '0;
         note_idx <= 3'd0;
         piezo    <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               piezo    <= 1'b0;
               freq_cnt <= '0;
               dur_cnt  <= '0;
               note_idx <= 3'd0;
               if (batt_low) begin
                  state    <= PLAY;
                  mel      <= MEL_LOW;
                  fan_pend <= fan_pend | fanfare;
               end else if (fanfare || fan_pend) begin
                  state    <= PLAY;
                  mel      <= MEL_FAN;
                  fan_pend <= 1'b0;
               end
            end

            PLAY, GAP: begin
               if (mel == MEL_FAN && batt_low) begin
                  // low battery wins: drop the fanfare and restart as the jingle
                  state    <= PLAY;
                  mel      <= MEL_LOW;
                  note_idx <= 3'd0;
                  freq_cnt <= '0;
                  dur_cnt  <= '0;
                  piezo    <= 1'b0;
               end else begin
                  if (fanfare && mel == MEL_LOW)
                     fan_pend <= 1'b1;
                  if (state == GAP) begin
                     piezo    <= 1'b0;
                     freq_cnt <= '0;
                     if (gap_end) begin
                        state    <= PLAY;
                        note_idx <= note_idx + 3'd1;
                        dur_cnt  <= '0;
                     end else begin
                        dur_cnt <= dur_sum[DUR_W-1:0];
                     end
                  end else begin
                     piezo <= tone_on;
                     if (note_end) begin
                        freq_cnt <= '0;
                        dur_cnt  <= '0;
                        if (last_note) begin
                           note_idx <= 3'd0;
                           if (!(mel == MEL_LOW && batt_low)) begin
                              state <= IDLE;
                              done  <= 1'b1;
                              piezo <= 1'b0;
                           end
                        end else if (GAP_CYC > 0) begin
                           state <= GAP;
                        end else begin
                           note_idx <= note_idx + 3'd1;
                        end
                     end else begin
                        dur_cnt  <= dur_sum[DUR_W-1:0];
                        freq_cnt <= freq_wrap ? '0 : freq_sum[FREQ_W-1:0];
                     end
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign piezo_n = ~piezo;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_piezo_seq.sv
// Directed bench for piezo_seq: vector table over fanfare, jingle, abort and queued-request runs, plus reset and volume sequences.
module tb_piezo_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       batt_low;
   logic       fanfare;
   logic       piezo;
   logic       piezo_n;
   logic       busy;
   logic [2:0] note_idx;
   logic       done;
`ifdef PIEZO_VOL_EN
   logic [1:0] vol;
`endif

   // 32768-clock beat at step 16: 2048 clocks per beat, longer than one G6 period
   piezo_seq #(
      .FAST_SIM(1),
      .BEAT_CYC(32768),
      .GAP_CYC (0),
      .DUR_W   (24),
      .FREQ_W  (15)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .batt_low(batt_low),
      .fanfare (fanfare),
`ifdef PIEZO_VOL_EN
      .vol     (vol),
`endif
      .piezo   (piezo),
      .piezo_n (piezo_n),
      .busy    (busy),
      .note_idx(note_idx),
      .done    (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         scn;
      int         t;
      logic       batt;
      logic       fan;
      logic       e_busy;
      logic [2:0] e_idx;
      logic [1:0] e_pz;   // 2 = don't care
      logic       e_done;
   } vec_t;

   vec_t vq[$];
   int   n_pass = 0;
   int   n_tot  = 0;
   int   cyc    = 0;
   int   done_cnt = 0;
   int   busy_cnt = 0;
   int   hi_cnt   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (done)  done_cnt++;
      if (busy)  busy_cnt++;
      if (piezo) hi_cnt++;
   endtask

   task automatic add(input int scn, input int t, input logic b, input logic f,
                      input logic bz, input logic [2:0] ix, input logic [1:0] pz, input logic d);
      vec_t v;
      v.scn = scn; v.t = t; v.batt = b; v.fan = f;
      v.e_busy = bz; v.e_idx = ix; v.e_pz = pz; v.e_done = d;
      vq.push_back(v);
   endtask

   initial begin
      int prev;
      rst_n    = 1'b0;
      batt_low = 1'b0;
      fanfare  = 1'b0;
`ifdef PIEZO_VOL_EN
      vol      = 2'd3;
`endif

      // fanfare: G6 C7 E7 G7(1.5) E7 G7(1.5) = 14336 clocks, with a retrigger that must be ignored
      add(1,     0, 0,1, 0,0,0,0);
      add(1,     1, 0,0, 1,0,0,0);
      add(1,     2, 0,0, 1,0,1,0);
      add(1,   998, 0,0, 1,0,1,0);
      add(1,   999, 0,0, 1,0,0,0);
      add(1,  1994, 0,0, 1,0,0,0);
      add(1,  1995, 0,0, 1,0,1,0);
      add(1,  2048, 0,0, 1,0,2,0);
      add(1,  2049, 0,0, 1,1,2,0);
      add(1,  2050, 0,0, 1,1,1,0);
      add(1,  2796, 0,0, 1,1,1,0);
      add(1,  2797, 0,0, 1,1,0,0);
      add(1,  3000, 0,1, 1,1,2,0);
      add(1,  3001, 0,0, 1,1,2,0);
      add(1,  4097, 0,0, 1,2,2,0);
      add(1,  6145, 0,0, 1,3,2,0);
      add(1,  9217, 0,0, 1,4,2,0);
      add(1, 11265, 0,0, 1,5,2,0);
      add(1, 14336, 0,0, 1,5,2,0);
      add(1, 14337, 0,0, 0,0,0,1);
      add(1, 14338, 0,0, 0,0,0,0);
      add(1, 14340, 0,0, 0,0,0,0);
      // jingle held for 2.5 passes: three passes, one done
      add(2,     0, 1,0, 0,0,0,0);
      add(2,     1, 1,0, 1,0,0,0);
      add(2,     2, 1,0, 1,0,1,0);
      add(2,  6144, 1,0, 1,2,2,0);
      add(2,  6145, 1,0, 1,0,2,0);
      add(2, 12288, 1,0, 1,2,2,0);
      add(2, 12289, 1,0, 1,0,2,0);
      add(2, 15361, 0,0, 1,1,2,0);
      add(2, 18432, 0,0, 1,2,2,0);
      add(2, 18433, 0,0, 0,0,0,1);
      add(2, 18434, 0,0, 0,0,0,0);
      // fanfare aborted by batt_low during G7
      add(3,     0, 0,1, 0,0,0,0);
      add(3,     1, 0,0, 1,0,0,0);
      add(3,  7000, 1,0, 1,3,2,0);
      add(3,  7001, 1,0, 1,0,0,0);
      add(3,  7002, 1,0, 1,0,1,0);
      add(3,  7010, 0,0, 1,0,2,0);
      add(3,  9048, 0,0, 1,0,2,0);
      add(3,  9049, 0,0, 1,1,2,0);
      add(3, 13144, 0,0, 1,2,2,0);
      add(3, 13145, 0,0, 0,0,0,1);
      add(3, 13146, 0,0, 0,0,0,0);
      add(3, 13200, 0,0, 0,0,0,0);
      // fanfare queued during jingle, starts one cycle after done
      add(4,     0, 1,0, 0,0,0,0);
      add(4,     1, 1,0, 1,0,0,0);
      add(4,  1000, 1,1, 1,0,2,0);
      add(4,  1001, 1,0, 1,0,2,0);
      add(4,  3000, 0,0, 1,1,2,0);
      add(4,  6144, 0,0, 1,2,2,0);
      add(4,  6145, 0,0, 0,0,0,1);
      add(4,  6146, 0,0, 1,0,0,0);
      add(4,  6147, 0,0, 1,0,1,0);
      add(4, 12289, 0,0, 1,2,2,0);
      add(4, 12290, 0,0, 1,3,2,0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_piezo_n", piezo_n, 1);
      rst_n = 1'b1;
      tick();

      prev = 0;
      foreach (vq[i]) begin
         if (vq[i].scn != prev) begin
            if (prev != 0) chk($sformatf("s%0d_done_count", prev), done_cnt, 1);
            cyc = 0;
            done_cnt = 0;
            prev = vq[i].scn;
         end
         while (cyc < vq[i].t) tick();
         chk($sformatf("s%0d_t%0d_busy", vq[i].scn, vq[i].t), busy, vq[i].e_busy);
         chk($sformatf("s%0d_t%0d_idx", vq[i].scn, vq[i].t), note_idx, vq[i].e_idx);
         chk($sformatf("s%0d_t%0d_done", vq[i].scn, vq[i].t), done, vq[i].e_done);
         if (vq[i].e_pz != 2'd2) begin
            chk($sformatf("s%0d_t%0d_piezo", vq[i].scn, vq[i].t), piezo, vq[i].e_pz[0]);
            chk($sformatf("s%0d_t%0d_piezo_n", vq[i].scn, vq[i].t), piezo_n, !vq[i].e_pz[0]);
         end
         batt_low = vq[i].batt;
         fanfare  = vq[i].fan;
      end
      chk("s4_done_count", done_cnt, 1);

      // async reset in the middle of the fanfare's G7
      #2 rst_n = 1'b0;
      #1;
      chk("rst4_busy", busy, 0);
      chk("rst4_piezo", piezo, 0);
      chk("rst4_idx", note_idx, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // async reset mid-G6 of a jingle with a pending fanfare: both lost
      tick();
      batt_low = 1'b1; fanfare = 1'b1;
      tick();
      batt_low = 1'b0; fanfare = 1'b0;
      repeat (5) tick();
      chk("s5_pre_piezo", piezo, 1);
      chk("s5_pre_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("s5_rst_piezo", piezo, 0);
      chk("s5_rst_piezo_n", piezo_n, 1);
      chk("s5_rst_busy", busy, 0);
      chk("s5_rst_done", done, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      busy_cnt = 0; done_cnt = 0;
      repeat (3000) tick();
      chk("s5_idle_busy_cycles", busy_cnt, 0);
      chk("s5_idle_done_count", done_cnt, 0);

`ifdef PIEZO_VOL_EN
      // vol=1: G6 high time 3986/16 -> 250 clocks
      vol = 2'd1;
      fanfare = 1'b1;
      tick();
      fanfare = 1'b0;
      cyc = 1;
      while (cyc < 251) tick();
      chk("vol1_t251_piezo", piezo, 1);
      tick();
      chk("vol1_t252_piezo", piezo, 0);
      hi_cnt = 0;
      while (cyc < 1994) tick();
      chk("vol1_first_period_high", hi_cnt, 0);
      tick();
      chk("vol1_second_period_rise", piezo, 1);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // vol=0: silent but sequenced normally
      vol = 2'd0;
      tick();
      fanfare = 1'b1;
      tick();
      fanfare = 1'b0;
      hi_cnt = 0; busy_cnt = 0; done_cnt = 0;
      repeat (14336) tick();
      chk("vol0_high_cycles", hi_cnt, 0);
      chk("vol0_busy_cycles", busy_cnt, 14335);
      chk("vol0_done_count", done_cnt, 1);
      chk("vol0_end_busy", busy, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
